// File: rtl/uart_cmd_pkg.sv
// Shared types and field layout for the UART command decoder.
// Byte layout: [7:6] nibble index, [5:2] payload nibble, [1:0] tag.
package uart_cmd_pkg;

    localparam logic [1:0] TAG_DEFAULT = 2'b01;
    localparam int TAG_LSB = 0;
    localparam int NIB_LSB = 2;
    localparam int IDX_LSB = 6;

    typedef enum logic {
        IDLE,
        COLLECT
    } state_t;

    function automatic int ceil4(input int n);
        return (n + 3) / 4;
    endfunction

endpackage

// File: rtl/cmd_timeout_counter.sv
// Loadable saturating cycle counter.
// expired pulses on the edge where the count would reach LIMIT.
module cmd_timeout_counter #(
    parameter int LIMIT = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic en,
    output logic expired
);

    localparam int W = $clog2(LIMIT + 1);
    localparam logic [W-1:0] TOP  = W'(LIMIT);
    localparam logic [W-1:0] LAST = W'(LIMIT - 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= '0;
        end else if (en && cnt != TOP) begin
            cnt <= cnt + 1'b1;
        end
    end

    // A load in the same cycle suppresses expiry.
    assign expired = en && !load && (cnt == LAST);

endmodule

// File: rtl/uart_cmd_decoder.sv
// Assembles tagged UART nibbles into a frame of control signals,
// committed atomically, with frame-gap and link watchdogs.
module uart_cmd_decoder
    import uart_cmd_pkg::*;
#(
    parameter int         CH_COUNT     = 4,
    parameter logic [1:0] TAG          = TAG_DEFAULT,
    parameter int         LINK_TIMEOUT = 50_000_000,
    parameter int         GAP_TIMEOUT  = 1_000_000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                data_valid,
    input  logic [7:0]          data_receive,
    output logic [CH_COUNT-1:0] sig_out,
    output logic [3:0]          feedback_leds,
    output logic                frame_done,
    output logic                frame_error,
    output logic                link_lost,
    output logic [7:0]          err_count
);

    localparam int NIB = ceil4(CH_COUNT);
    localparam int SW  = 4 * NIB;

    state_t      state, state_d;
    logic [1:0]  exp_idx, exp_d;
    logic [SW-1:0] shadow, shadow_d;
    logic        commit, err;
    logic        gap_exp, link_exp;

    logic [1:0] tag, idx;
    logic [3:0] nib;

    assign tag = data_receive[TAG_LSB+:2];
    assign nib = data_receive[NIB_LSB+:4];
    assign idx = data_receive[IDX_LSB+:2];

    cmd_timeout_counter #(.LIMIT(GAP_TIMEOUT)) u_gap (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (data_valid || state == IDLE),
        .en      (state == COLLECT),
        .expired (gap_exp)
    );

    cmd_timeout_counter #(.LIMIT(LINK_TIMEOUT)) u_link (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (commit),
        .en      (1'b1),
        .expired (link_exp)
    );

    always_comb begin
        state_d  = state;
        exp_d    = exp_idx;
        shadow_d = shadow;
        commit   = 1'b0;
        err      = 1'b0;
        if (data_valid) begin
            if (tag != TAG) begin
                err     = 1'b1;
                state_d = IDLE;
            end else if (idx == 2'd0) begin
                shadow_d[3:0] = nib;
                exp_d         = 2'd1;
                if (NIB == 1) begin
                    commit  = 1'b1;
                    state_d = IDLE;
                end else begin
                    state_d = COLLECT;
                end
            end else if (state == COLLECT && idx == exp_idx) begin
                for (int i = 1; i < NIB; i++) begin
                    if (idx == 2'(i)) shadow_d[4*i+:4] = nib;
                end
                if (idx == 2'(NIB - 1)) begin
                    commit  = 1'b1;
                    state_d = IDLE;
                end else begin
                    exp_d = exp_idx + 2'd1;
                end
            end else begin
                err     = 1'b1;
                state_d = IDLE;
            end
        end else if (gap_exp) begin
            err     = 1'b1;
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            exp_idx     <= 2'd0;
            shadow      <= '0;
            sig_out     <= '0;
            frame_done  <= 1'b0;
            frame_error <= 1'b0;
            link_lost   <= 1'b1;
            err_count   <= 8'd0;
        end else begin
            state       <= state_d;
            exp_idx     <= exp_d;
            shadow      <= shadow_d;
            frame_done  <= commit;
            frame_error <= err;
            // Commit takes priority over watchdog expiry.
            if (commit) begin
                sig_out   <= shadow_d[CH_COUNT-1:0];
                link_lost <= 1'b0;
            end else if (link_exp) begin
                sig_out   <= '0;
                link_lost <= 1'b1;
            end
            if (err && err_count != 8'hFF) begin
                err_count <= err_count + 8'd1;
            end
        end
    end

    if (CH_COUNT >= 4) begin : g_led
        assign feedback_leds = sig_out[3:0];
    end else begin : g_led_pad
        assign feedback_leds = {{(4 - CH_COUNT){1'b0}}, sig_out};
    end

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Directed bench for uart_cmd_decoder with three configurations:
// 4 channels/short link, 12 channels, 8 channels/short gap.
module tb_uart_cmd_decoder;

    logic clk = 1'b0;
    logic rst_n;
    logic dv [3];
    logic [7:0] db [3];

    logic [3:0]  so4;
    logic [11:0] so12;
    logic [7:0]  so8;
    logic [3:0]  led [3];
    logic fd [3];
    logic fe [3];
    logic ll [3];
    logic [7:0] ec [3];

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    uart_cmd_decoder #(
        .CH_COUNT(4), .LINK_TIMEOUT(20), .GAP_TIMEOUT(1000)
    ) u4 (
        .clk(clk), .rst_n(rst_n),
        .data_valid(dv[0]), .data_receive(db[0]),
        .sig_out(so4), .feedback_leds(led[0]),
        .frame_done(fd[0]), .frame_error(fe[0]),
        .link_lost(ll[0]), .err_count(ec[0])
    );

    uart_cmd_decoder #(
        .CH_COUNT(12), .LINK_TIMEOUT(5000), .GAP_TIMEOUT(1000)
    ) u12 (
        .clk(clk), .rst_n(rst_n),
        .data_valid(dv[1]), .data_receive(db[1]),
        .sig_out(so12), .feedback_leds(led[1]),
        .frame_done(fd[1]), .frame_error(fe[1]),
        .link_lost(ll[1]), .err_count(ec[1])
    );

    uart_cmd_decoder #(
        .CH_COUNT(8), .LINK_TIMEOUT(5000), .GAP_TIMEOUT(10)
    ) u8 (
        .clk(clk), .rst_n(rst_n),
        .data_valid(dv[2]), .data_receive(db[2]),
        .sig_out(so8), .feedback_leds(led[2]),
        .frame_done(fd[2]), .frame_error(fe[2]),
        .link_lost(ll[2]), .err_count(ec[2])
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] mk(input logic [1:0] idx,
                                      input logic [3:0] nib,
                                      input logic [1:0] tg);
        return {idx, nib, tg};
    endfunction

    // Drive one byte for one cycle; returns at the negedge after sampling.
    task automatic send(input int w, input logic [7:0] b);
        dv[w] = 1'b1;
        db[w] = b;
        @(negedge clk);
        dv[w] = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            dv[i] = 1'b0;
            db[i] = 8'h00;
        end
        idle(2);
        chk("rst_sig", 32'(so4), 32'h0);
        chk("rst_led", 32'(led[0]), 32'h0);
        chk("rst_done", 32'(fd[0]), 32'h0);
        chk("rst_err", 32'(fe[0]), 32'h0);
        chk("rst_lost", 32'(ll[0]), 32'h1);
        chk("rst_cnt", 32'(ec[0]), 32'h0);
        rst_n = 1'b1;
        idle(1);

        // 4-channel single-byte frame
        send(0, mk(2'd0, 4'b1011, 2'b01));
        chk("c4_sig", 32'(so4), 32'hB);
        chk("c4_done", 32'(fd[0]), 32'h1);
        chk("c4_led", 32'(led[0]), 32'hB);
        chk("c4_lost", 32'(ll[0]), 32'h0);
        idle(1);
        chk("c4_done_pulse", 32'(fd[0]), 32'h0);

        // link watchdog expires 20 edges after the last commit
        send(0, mk(2'd0, 4'hF, 2'b01));
        idle(19);
        chk("link_pre_sig", 32'(so4), 32'hF);
        chk("link_pre_lost", 32'(ll[0]), 32'h0);
        idle(1);
        chk("link_exp_sig", 32'(so4), 32'h0);
        chk("link_exp_lost", 32'(ll[0]), 32'h1);

        // commit on the exact expiry edge wins
        send(0, mk(2'd0, 4'hF, 2'b01));
        idle(19);
        send(0, mk(2'd0, 4'h6, 2'b01));
        chk("link_race_sig", 32'(so4), 32'h6);
        chk("link_race_lost", 32'(ll[0]), 32'h0);
        idle(1);
        chk("link_race_hold", 32'(so4), 32'h6);

        // 12-channel, three nibbles back to back
        send(1, mk(2'd0, 4'h5, 2'b01));
        chk("c12_b0_sig", 32'(so12), 32'h0);
        chk("c12_b0_done", 32'(fd[1]), 32'h0);
        send(1, mk(2'd1, 4'hA, 2'b01));
        chk("c12_b1_sig", 32'(so12), 32'h0);
        send(1, mk(2'd2, 4'h3, 2'b01));
        chk("c12_b2_sig", 32'(so12), 32'h3A5);
        chk("c12_b2_done", 32'(fd[1]), 32'h1);

        // skipped index
        send(1, mk(2'd0, 4'h1, 2'b01));
        send(1, mk(2'd2, 4'h2, 2'b01));
        chk("skip_err", 32'(fe[1]), 32'h1);
        chk("skip_cnt", 32'(ec[1]), 32'h1);
        chk("skip_sig", 32'(so12), 32'h3A5);
        send(1, mk(2'd0, 4'h7, 2'b01));
        send(1, mk(2'd1, 4'h8, 2'b01));
        send(1, mk(2'd2, 4'h9, 2'b01));
        chk("restart_sig", 32'(so12), 32'h987);
        chk("restart_cnt", 32'(ec[1]), 32'h1);

        // bad tag and saturation
        send(1, mk(2'd0, 4'hF, 2'b10));
        chk("tag_err", 32'(fe[1]), 32'h1);
        chk("tag_done", 32'(fd[1]), 32'h0);
        chk("tag_cnt", 32'(ec[1]), 32'h2);
        chk("tag_sig", 32'(so12), 32'h987);
        for (int i = 0; i < 300; i++) send(1, mk(2'd0, 4'h1, 2'b10));
        chk("sat_cnt", 32'(ec[1]), 32'hFF);
        chk("sat_sig", 32'(so12), 32'h987);

        // 8-channel: baseline frame, then gap timeout
        send(2, mk(2'd0, 4'h2, 2'b01));
        send(2, mk(2'd1, 4'h9, 2'b01));
        chk("c8_sig", 32'(so8), 32'h92);
        send(2, mk(2'd0, 4'hC, 2'b01));
        idle(9);
        chk("gap_pre_err", 32'(fe[2]), 32'h0);
        idle(1);
        chk("gap_err", 32'(fe[2]), 32'h1);
        chk("gap_sig", 32'(so8), 32'h92);
        send(2, mk(2'd1, 4'h3, 2'b01));
        chk("gap_idle_err", 32'(fe[2]), 32'h1);
        chk("gap_cnt", 32'(ec[2]), 32'h2);
        chk("gap_idle_sig", 32'(so8), 32'h92);

        // byte arriving on the gap-expiry edge wins
        send(2, mk(2'd0, 4'h4, 2'b01));
        idle(9);
        send(2, mk(2'd1, 4'h5, 2'b01));
        chk("gap_race_sig", 32'(so8), 32'h54);
        chk("gap_race_err", 32'(fe[2]), 32'h0);

        // index beyond frame length
        send(2, mk(2'd0, 4'h1, 2'b01));
        send(2, mk(2'd2, 4'h1, 2'b01));
        chk("oor_err", 32'(fe[2]), 32'h1);
        chk("oor_cnt", 32'(ec[2]), 32'h3);

        // asynchronous reset mid-frame
        send(2, mk(2'd0, 4'hE, 2'b01));
        #2 rst_n = 1'b0;
        #1;
        chk("arst_sig", 32'(so8), 32'h0);
        chk("arst_led", 32'(led[2]), 32'h0);
        chk("arst_lost", 32'(ll[2]), 32'h1);
        chk("arst_cnt", 32'(ec[2]), 32'h0);
        chk("arst_sig4", 32'(so4), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(1);
        send(2, mk(2'd1, 4'h3, 2'b01));
        chk("arst_idle_err", 32'(fe[2]), 32'h1);
        chk("arst_idle_cnt", 32'(ec[2]), 32'h1);
        chk("arst_idle_sig", 32'(so8), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
